hazard_ctrl: RTL

Pipeline controller for the 5-stage core. It generates stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use and data hazards and squashes wrong-path fetches on a taken branch. It also runs the handshake with a multi-cycle data memory, freezing the pipeline while an access in MEM is outstanding and flagging a sticky error on timeout.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and memory-wait stalls, branch squash,
// EX operand forwarding and the multi-cycle data-memory handshake.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic [4:0]           rsE,
    input  logic [4:0]           rtE,
    input  logic [4:0]           wirteRegAddrE,
    input  logic [4:0]           wirteRegAddrM,
    input  logic [4:0]           wirteRegAddrW,
    input  logic                 Regfile_weE,
    input  logic                 Regfile_weM,
    input  logic                 Regfile_weW,
    input  logic                 memToRegE,
    input  logic                 memReadM,
    input  logic                 DataMem_weM,
    input  logic                 branchTakenD,
    input  logic                 mem_ready,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 flushW,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic                 mem_req,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [1:0]           r_state;
    logic [WC_W-1:0]      r_wait_cnt;
    logic                 r_mem_err;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic [1:0]           w_state_next;
    logic [WC_W-1:0]      w_wait_cnt_next;
    logic                 w_mem_err_next;

    logic                 w_memop;
    logic                 w_mem_stall;
    logic                 w_load_use;
    logic                 w_stall_f;
    logic                 w_stall_d;
    logic                 w_flush_d;
    logic                 w_flush_e;
    logic [4:0]           w_src [2];
    logic [1:0]           w_fwd [2];
    logic                 w_unused;

    // EX write-enable is implied by memToRegE for the only EX hazard we resolve.
    assign w_unused = Regfile_weE;

    assign w_memop = memReadM | DataMem_weM;

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_mem_err_next  = r_mem_err;
        w_mem_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_memop && !mem_ready) begin
                    w_state_next    = ST_WAIT;
                    w_wait_cnt_next = WC_ONE;
                    w_mem_stall     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_state_next    = ST_RUN;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == WC_LAST) begin
                    w_state_next   = ST_ERR;
                    w_mem_err_next = 1'b1;
                    w_mem_stall    = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WC_ONE;
                    w_mem_stall     = 1'b1;
                end
            end
            ST_ERR: begin
                w_mem_err_next = 1'b1;
                w_mem_stall    = 1'b1;
            end
            default: begin
                w_state_next    = ST_RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    assign w_load_use = memToRegE && (wirteRegAddrE != 5'd0)
                        && ((wirteRegAddrE == rsD) || (wirteRegAddrE == rtD));

    // Memory stall dominates; a load-use stall hides the branch because its operands are stale.
    assign w_stall_f = w_mem_stall | w_load_use;
    assign w_stall_d = w_mem_stall | w_load_use;
    assign w_flush_e = !w_mem_stall & w_load_use;
    assign w_flush_d = !w_mem_stall & !w_load_use & branchTakenD;

    assign w_src[0] = rsE;
    assign w_src[1] = rtE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] =
                (Regfile_weM && (wirteRegAddrM != 5'd0) && (wirteRegAddrM == w_src[gi])) ? 2'b10 :
                (Regfile_weW && (wirteRegAddrW != 5'd0) && (wirteRegAddrW == w_src[gi])) ? 2'b01 :
                2'b00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_mem_err  <= w_mem_err_next;
            if (w_stall_f && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Control outputs are gated by reset so they drop the instant rst goes low.
    assign stallF    = rst & w_stall_f;
    assign stallD    = rst & w_stall_d;
    assign stallE    = rst & w_mem_stall;
    assign stallM    = rst & w_mem_stall;
    assign flushD    = rst & w_flush_d;
    assign flushE    = rst & w_flush_e;
    assign flushW    = rst & w_mem_stall;
    assign forwardAE = {2{rst}} & w_fwd[0];
    assign forwardBE = {2{rst}} & w_fwd[1];
    assign mem_req   = rst & w_memop & (r_state != ST_ERR);
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule
